// File: rtl/watch_pkg.sv
// Shared constants for the watch time-setting controller: field indices, ranges, FSM encoding,
// bit offsets of each field in the 48-bit time vector, and the range-aware inc/dec helper.
package watch_pkg;

    typedef logic [47:0] time_vec_t;

    localparam logic [2:0] FLD_YEAR  = 3'd0;
    localparam logic [2:0] FLD_MONTH = 3'd1;
    localparam logic [2:0] FLD_DAY   = 3'd2;
    localparam logic [2:0] FLD_HOUR  = 3'd3;
    localparam logic [2:0] FLD_MIN   = 3'd4;
    localparam logic [2:0] FLD_SEC   = 3'd5;
    localparam logic [2:0] FLD_NONE  = 3'd7;

    localparam logic [7:0] YEAR_MIN  = 8'd0;
    localparam logic [7:0] YEAR_MAX  = 8'd255;
    localparam logic [7:0] MONTH_MIN = 8'd1;
    localparam logic [7:0] MONTH_MAX = 8'd12;
    localparam logic [7:0] DAY_MIN   = 8'd1;
    localparam logic [7:0] HOUR_MIN  = 8'd0;
    localparam logic [7:0] HOUR_MAX  = 8'd23;
    localparam logic [7:0] MIN_MIN   = 8'd0;
    localparam logic [7:0] MIN_MAX   = 8'd59;
    localparam logic [7:0] SEC_MIN   = 8'd0;
    localparam logic [7:0] SEC_MAX   = 8'd59;

    // Edit states are contiguous so that state+1 is the next field and state-1 is its index.
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_E_YEAR  = 3'd1;
    localparam logic [2:0] ST_E_MONTH = 3'd2;
    localparam logic [2:0] ST_E_DAY   = 3'd3;
    localparam logic [2:0] ST_E_HOUR  = 3'd4;
    localparam logic [2:0] ST_E_MIN   = 3'd5;
    localparam logic [2:0] ST_E_SEC   = 3'd6;
    localparam logic [2:0] ST_COMMIT  = 3'd7;

    localparam int OFS_YEAR  = 40;
    localparam int OFS_MONTH = 32;
    localparam int OFS_DAY   = 24;
    localparam int OFS_HOUR  = 16;
    localparam int OFS_MIN   = 8;
    localparam int OFS_SEC   = 0;

    // An out-of-range value snaps to the near end of the range for the direction pressed.
    function automatic logic [7:0] fld_step(input logic [7:0] v, input logic [7:0] lo,
                                            input logic [7:0] hi, input logic up);
        if (v < lo || v > hi)
            return up ? lo : hi;
        if (up)
            return (v == hi) ? lo : v + 8'd1;
        return (v == lo) ? hi : v - 8'd1;
    endfunction

endpackage

// File: rtl/watch_month_len.sv
// Month length lookup (no leap years); an illegal month yields 0.
module watch_month_len (
    input  logic [7:0] month,
    output logic [7:0] maxday
);
    always_comb begin
        maxday = 8'd0;
        case (month)
            8'd1, 8'd3, 8'd5, 8'd7, 8'd8, 8'd10, 8'd12: maxday = 8'd31;
            8'd2:                                       maxday = 8'd28;
            8'd4, 8'd6, 8'd9, 8'd11:                    maxday = 8'd30;
            default:                                    maxday = 8'd0;
        endcase
    end
endmodule

// File: rtl/watch_set_ctrl.sv
// Button-driven date/time setting FSM: captures the live time, edits it field by field,
// and loads it back into the counter with a one-cycle set_time strobe.
module watch_set_ctrl
    import watch_pkg::*;
#(
    parameter int         TIMEOUT_SEC = 30,
    parameter logic [7:0] RST_YEAR    = 8'd21,
    parameter logic [7:0] RST_MONTH   = 8'd5,
    parameter logic [7:0] RST_DAY     = 8'd30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk1sec,
    input  logic        btn_mode,
    input  logic        btn_inc,
    input  logic        btn_dec,
    input  logic        btn_cancel,
    input  logic [47:0] cur_time,
    output logic [47:0] bin_time,
    output logic        set_time,
    output logic        editing,
    output logic [2:0]  edit_field,
    output logic        blink
);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_SEC - 1);

    logic [2:0]  r_state;
    time_vec_t   r_shadow;
    logic        r_set;
    logic        r_editing;
    logic [2:0]  r_fld;
    logic        r_blink;
    logic [7:0]  r_tmo;

    logic        w_any_btn;
    logic        w_timeout;
    logic [7:0]  w_month_next;
    logic [7:0]  w_maxday_cur;
    logic [7:0]  w_maxday_next;
    time_vec_t   w_edit_val;

    assign w_any_btn    = btn_mode | btn_inc | btn_dec;
    assign w_timeout    = !w_any_btn && clk1sec && (r_tmo == TMO_LAST);
    assign w_month_next = fld_step(r_shadow[OFS_MONTH +: 8], MONTH_MIN, MONTH_MAX, btn_inc);

    watch_month_len u_len_cur (
        .month  (r_shadow[OFS_MONTH +: 8]),
        .maxday (w_maxday_cur)
    );

    watch_month_len u_len_next (
        .month  (w_month_next),
        .maxday (w_maxday_next)
    );

    always_comb begin
        w_edit_val = r_shadow;
        case (r_state)
            ST_E_YEAR:  w_edit_val[OFS_YEAR +: 8] =
                            fld_step(r_shadow[OFS_YEAR +: 8], YEAR_MIN, YEAR_MAX, btn_inc);
            ST_E_MONTH: begin
                w_edit_val[OFS_MONTH +: 8] = w_month_next;
                if (r_shadow[OFS_DAY +: 8] > w_maxday_next)
                    w_edit_val[OFS_DAY +: 8] = w_maxday_next;
            end
            ST_E_DAY:   w_edit_val[OFS_DAY +: 8] =
                            fld_step(r_shadow[OFS_DAY +: 8], DAY_MIN, w_maxday_cur, btn_inc);
            ST_E_HOUR:  w_edit_val[OFS_HOUR +: 8] =
                            fld_step(r_shadow[OFS_HOUR +: 8], HOUR_MIN, HOUR_MAX, btn_inc);
            ST_E_MIN:   w_edit_val[OFS_MIN +: 8] =
                            fld_step(r_shadow[OFS_MIN +: 8], MIN_MIN, MIN_MAX, btn_inc);
            ST_E_SEC:   w_edit_val[OFS_SEC +: 8] =
                            fld_step(r_shadow[OFS_SEC +: 8], SEC_MIN, SEC_MAX, btn_inc);
            default:    w_edit_val = r_shadow;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_shadow  <= {RST_YEAR, RST_MONTH, RST_DAY, 24'd0};
            r_set     <= 1'b0;
            r_editing <= 1'b0;
            r_fld     <= FLD_NONE;
            r_blink   <= 1'b0;
            r_tmo     <= 8'd0;
        end else begin
            r_set <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (btn_mode) begin
                        r_shadow  <= cur_time;
                        r_state   <= ST_E_YEAR;
                        r_editing <= 1'b1;
                        r_fld     <= FLD_YEAR;
                        r_tmo     <= 8'd0;
                        r_blink   <= 1'b0;
                    end
                end
                ST_COMMIT: r_state <= ST_IDLE;
                default: begin
                    if (btn_cancel || w_timeout) begin
                        r_state   <= ST_IDLE;
                        r_editing <= 1'b0;
                        r_fld     <= FLD_NONE;
                        r_tmo     <= 8'd0;
                        r_blink   <= 1'b0;
                    end else if (btn_mode) begin
                        r_state <= r_state + 3'd1;
                        r_tmo   <= 8'd0;
                        if (r_state == ST_E_SEC) begin
                            r_set     <= 1'b1;
                            r_editing <= 1'b0;
                            r_fld     <= FLD_NONE;
                            r_blink   <= 1'b0;
                        end else begin
                            r_fld <= r_state;
                            if (clk1sec)
                                r_blink <= ~r_blink;
                        end
                    end else if (btn_inc || btn_dec) begin
                        // inc+dec together is activity only; the field is left alone.
                        r_tmo   <= 8'd0;
                        r_blink <= 1'b1;
                        if (btn_inc ^ btn_dec)
                            r_shadow <= w_edit_val;
                    end else if (clk1sec) begin
                        r_tmo   <= r_tmo + 8'd1;
                        r_blink <= ~r_blink;
                    end
                end
            endcase
        end
    end

    assign bin_time   = r_shadow;
    assign set_time   = r_set;
    assign editing    = r_editing;
    assign edit_field = r_fld;
    assign blink      = r_blink;

endmodule

// File: doc/watch_set_ctrl.md
Name: watch_set_ctrl

Overview:
- Button-driven time-setting controller for the watch date/time counter.
- Captures the live date/time into a shadow register and walks the user through year, month, day, hour, minute and second fields with inc/dec editing.
- Loads the edited value into the counter through the counter's bin_time bus and its one-cycle set_time strobe.
- Sits between the debounced button front-end and the date/time counter; also drives field-select and blink signals for the display.

Parameters:
- TIMEOUT_SEC, 30, number of clk1sec pulses without a button event before an edit session aborts; legal range 1..255.
- RST_YEAR, 21, shadow year value at reset.
- RST_MONTH, 5, shadow month value at reset.
- RST_DAY, 30, shadow day value at reset.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high; sampled on the rising edge of clk.
- clk1sec  in  1  one-clk-wide pulse, once per second.
- btn_mode  in  1  single-cycle pulse: enter edit, or advance to the next field.
- btn_inc  in  1  single-cycle pulse: increment the current field.
- btn_dec  in  1  single-cycle pulse: decrement the current field.
- btn_cancel  in  1  single-cycle pulse: abort the session with no load.
- cur_time  in  48  live {year,month,day,hour,minute,second} from the counter, 8 bits each.
- bin_time  out  48  shadow {year,month,day,hour,minute,second}; feeds the counter load bus.
- set_time  out  1  one-cycle load strobe to the counter.
- editing  out  1  high in any edit state.
- edit_field  out  3  field being edited: 0=year, 1=month, 2=day, 3=hour, 4=minute, 5=second, 7=none.
- blink  out  1  display blink phase for the edited field.

Behaviour:
- Reset (rst=1 at a clk edge):
  - FSM goes to IDLE.
  - bin_time = {RST_YEAR,RST_MONTH,RST_DAY,0,0,0}.
  - set_time=0, editing=0, edit_field=7, blink=0, timeout counter=0.
  - Reset mid-session discards edits; set_time is never issued as a result of reset.
- States: IDLE, E_YEAR, E_MONTH, E_DAY, E_HOUR, E_MIN, E_SEC, COMMIT.
- IDLE:
  - btn_mode: shadow <= cur_time, go to E_YEAR next cycle.
  - All other buttons are ignored.
- Field advance: btn_mode in E_x moves to the next field (E_YEAR->E_MONTH->...->E_SEC->COMMIT).
- COMMIT:
  - Lasts exactly one cycle; set_time=1 with bin_time stable.
  - Then IDLE.
  - bin_time is held unchanged in IDLE.
- Abort (btn_cancel, or timeout) in any E_x state:
  - Go to IDLE, no set_time.
  - Shadow holds the last edited value; it is not reloaded until the next entry.
- Button priority within a cycle: btn_cancel > btn_mode > inc/dec.
- inc and dec asserted together leave the field unchanged, but still count as activity.
- Field update applies on the clock edge the button is sampled; visible on bin_time the next cycle.
- Field ranges and wrap:
  - Year: 0..255, 8-bit modular (255+1=0, 0-1=255).
  - Month: 1..12 (12+1=1, 1-1=12).
  - Day: 1..maxday(month), where maxday is 31 for months 1,3,5,7,8,10,12; 28 for month 2; 30 for months 4,6,9,11. No leap years.
  - Day wrap: maxday+1=1, 1-1=maxday.
  - Hour: 0..23.
  - Minute and second: 0..59.
- Clamp on month change: if day > maxday(new month), day <= maxday(new month) in the same cycle as the month update.
- Out-of-range capture: if the captured cur_time holds an illegal field value, the first inc/dec on that field first clamps it into range (to max for dec, to min for inc); no further correction is applied.
- Timeout:
  - Counter increments on clk1sec while editing.
  - Clears to 0 on any button pulse and on entry to an edit state.
  - When it reaches TIMEOUT_SEC, abort at that clk1sec edge.
  - A button pulse on the same cycle as the expiring clk1sec wins: it is processed and the counter is cleared.
- blink:
  - Toggles on each clk1sec while editing.
  - Forced to 1 for the cycle after any inc/dec.
  - 0 in IDLE and COMMIT.
- Outputs are registered. edit_field=7 and editing=0 in IDLE and COMMIT.

Decomposition:
- Shared package watch_pkg holds:
  - Field index constants FLD_YEAR..FLD_SEC and FLD_NONE=7.
  - Per-field min/max constants: 0/255, 1/12, 1/-, 0/23, 0/59, 0/59.
  - FSM state encoding.
  - The 48-bit time-vector field offsets.
- One sub-module: watch_month_len (combinational month -> maxday; illegal month -> 0). Instantiate it twice, once for the current month and once for the next month value used in the clamp.
- The wrap inc/dec logic is a function in watch_pkg.

Test Plan:
- Enter/commit: cur_time={21,5,30,10,20,30}. Sequence btn_mode, btn_inc (year), then btn_mode x6 -> exactly one set_time pulse with bin_time={22,5,30,10,20,30}; editing=0 afterward.
- Wraps:
  - Hour 23 + inc -> 0.
  - Minute 0 + dec -> 59.
  - Month 12 + inc -> 1.
  - Year 255 + inc -> 0.
  - Day 1 with month=4, + dec -> 30.
- Clamp: shadow month=1, day=31; in E_MONTH press inc -> month=2, day=28 on the same cycle; press inc again -> month=3, day stays 28.
- Timeout: TIMEOUT_SEC=3; enter edit, send 3 clk1sec pulses with no buttons -> IDLE after the 3rd, set_time never asserted. Repeat with btn_inc coincident with the 3rd clk1sec -> stays in E_YEAR.
- Cancel/priority:
  - btn_cancel+btn_mode in the same cycle in E_HOUR -> IDLE, no set_time.
  - btn_inc+btn_dec together -> field unchanged.
- Reset: assert rst in E_SEC -> next cycle IDLE, set_time=0, bin_time={21,5,30,0,0,0}, edit_field=7.
